// File: rtl/counter_pkg.sv
// Shared definitions for the down-counting timer: FSM state encoding and legal width range.
// No logic; imported by the timer top level.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/counter_down_core.sv
// WIDTH-bit down-counter register with synchronous load, decrement enable and is_one flag.
// Latency: load/decrement visible one cycle after the edge. No backpressure; load wins over dec.
module counter_down_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             is_one
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec) begin
            count <= count - 1'b1;
        end
    end

    assign is_one = (count == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/counter_down_sync_timer.sv
// Down-counting interval timer with reload register, one-shot/periodic modes and a one-cycle tc pulse.
// Latency: start loads count_out for the next cycle; tc_out follows the 1->reload/0 edge. No backpressure.
module counter_down_sync_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_ah_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_value_in,
    input  logic             start_in,
    input  logic             stop_in,
    input  logic             enable_in,
    input  logic             mode_in,
    output logic [WIDTH-1:0] count_out,
    output logic             tc_out,
    output logic             busy_out
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("counter_down_sync_timer: WIDTH out of range");
    end

    timer_state_t     state_q, state_nxt;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] r_eff;
    logic             mode_q, mode_nxt;
    logic             tc_nxt;
    logic             core_load, core_dec;
    logic             is_one;
    logic             start_ok;

    assign r_eff    = load_in ? load_value_in : reload_q;
    assign start_ok = start_in && !stop_in && (r_eff != '0);

    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            reload_q <= '0;
        end else if (load_in) begin
            reload_q <= load_value_in;
        end
    end

    always_comb begin
        state_nxt = state_q;
        mode_nxt  = mode_q;
        tc_nxt    = 1'b0;
        core_load = 1'b0;
        core_dec  = 1'b0;
        if (start_ok) begin
            // A start always wins over counting, so a restart at count 1 emits no tc.
            state_nxt = RUN;
            mode_nxt  = mode_in;
            core_load = 1'b1;
        end else if (state_q == RUN) begin
            if (stop_in) begin
                state_nxt = IDLE;
            end else if (enable_in) begin
                if (is_one) begin
                    tc_nxt = 1'b1;
                    if (mode_q && (r_eff != '0)) begin
                        core_load = 1'b1;
                    end else begin
                        // One-shot, or a periodic reload of zero: park at 0 rather than wrap.
                        core_load = mode_q;
                        core_dec  = !mode_q;
                        state_nxt = EXPIRED;
                    end
                end else begin
                    core_dec = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            tc_out   <= 1'b0;
            busy_out <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            mode_q   <= mode_nxt;
            tc_out   <= tc_nxt;
            busy_out <= (state_nxt == RUN);
        end
    end

    counter_down_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (reset_ah_in),
        .load       (core_load),
        .load_value (r_eff),
        .dec        (core_dec),
        .count      (count_out),
        .is_one     (is_one)
    );

endmodule

// File: tb/tb_counter_down_sync_timer.sv
// Directed self-checking bench for counter_down_sync_timer (WIDTH=4).
module tb_counter_down_sync_timer;

    logic       clk = 1'b0;
    logic       reset_ah_in;
    logic       load_in;
    logic [3:0] load_value_in;
    logic       start_in;
    logic       stop_in;
    logic       enable_in;
    logic       mode_in;
    logic [3:0] count_out;
    logic       tc_out;
    logic       busy_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    counter_down_sync_timer #(.WIDTH(4)) dut (
        .clk           (clk),
        .reset_ah_in   (reset_ah_in),
        .load_in       (load_in),
        .load_value_in (load_value_in),
        .start_in      (start_in),
        .stop_in       (stop_in),
        .enable_in     (enable_in),
        .mode_in       (mode_in),
        .count_out     (count_out),
        .tc_out        (tc_out),
        .busy_out      (busy_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        load_in       = 1'b0;
        load_value_in = 4'd0;
        start_in      = 1'b0;
        stop_in       = 1'b0;
        enable_in     = 1'b0;
        mode_in       = 1'b0;
    endtask

    task automatic test_reset();
        reset_ah_in = 1'b1;
        clear_inputs();
        #1;
        n_checks++;
        if ({count_out, tc_out, busy_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_asserted count=%0d tc=%b busy=%b required 0/0/0", count_out, tc_out, busy_out);
        end
        tick();
        reset_ah_in = 1'b0;
        tick(); tick();
        n_checks++;
        if ({count_out, tc_out, busy_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_idle count=%0d tc=%b busy=%b required 0/0/0", count_out, tc_out, busy_out);
        end
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        n_checks++;
        if (busy_out !== 1'b0 || count_out !== 4'd0) begin
            n_fail++;
            $display("FAIL start_r0_ignored busy=%b count=%0d required busy=0 count=0", busy_out, count_out);
        end
    endtask

    task automatic test_one_shot();
        logic [3:0] exp_cnt [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        load_in = 1'b1; load_value_in = 4'd5;
        tick();
        load_in = 1'b0;
        n_checks++;
        if (count_out !== 4'd0) begin
            n_fail++;
            $display("FAIL load_no_count_change count=%0d required 0", count_out);
        end
        mode_in = 1'b0; enable_in = 1'b1; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        n_checks++;
        if (count_out !== 4'd5 || busy_out !== 1'b1 || tc_out !== 1'b0) begin
            n_fail++;
            $display("FAIL one_shot_start count=%0d busy=%b tc=%b required 5/1/0", count_out, busy_out, tc_out);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (count_out !== exp_cnt[i] || tc_out !== (i == 4) || busy_out !== (i != 4)) begin
                n_fail++;
                $display("FAIL one_shot_step%0d count=%0d tc=%b busy=%b required %0d/%b/%b",
                         i, count_out, tc_out, busy_out, exp_cnt[i], (i == 4), (i != 4));
            end
        end
        tick(); tick();
        n_checks++;
        if (count_out !== 4'd0 || tc_out !== 1'b0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL expired_hold count=%0d tc=%b busy=%b required 0/0/0", count_out, tc_out, busy_out);
        end
        enable_in = 1'b0;
    endtask

    task automatic test_periodic();
        logic [3:0] exp_cnt [9] = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
        load_in = 1'b1; load_value_in = 4'd3;
        tick();
        load_in = 1'b0;
        mode_in = 1'b1; start_in = 1'b1; enable_in = 1'b1;
        tick();
        start_in = 1'b0;
        n_checks++;
        if (count_out !== 4'd3 || busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL periodic_start count=%0d busy=%b required 3/1", count_out, busy_out);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            n_checks++;
            if (count_out !== exp_cnt[i] || tc_out !== (exp_cnt[i] == 4'd3) || busy_out !== 1'b1) begin
                n_fail++;
                $display("FAIL periodic_r3_step%0d count=%0d tc=%b busy=%b required %0d/%b/1",
                         i, count_out, tc_out, busy_out, exp_cnt[i], (exp_cnt[i] == 4'd3));
            end
        end
        stop_in = 1'b1; enable_in = 1'b0;
        tick();
        stop_in = 1'b0;
        load_in = 1'b1; load_value_in = 4'd1; start_in = 1'b1; mode_in = 1'b1;
        tick();
        load_in = 1'b0; start_in = 1'b0; enable_in = 1'b1;
        n_checks++;
        if (count_out !== 4'd1 || tc_out !== 1'b0) begin
            n_fail++;
            $display("FAIL periodic_r1_start count=%0d tc=%b required 1/0", count_out, tc_out);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (count_out !== 4'd1 || tc_out !== 1'b1 || busy_out !== 1'b1) begin
                n_fail++;
                $display("FAIL periodic_r1_step%0d count=%0d tc=%b busy=%b required 1/1/1",
                         i, count_out, tc_out, busy_out);
            end
        end
        stop_in = 1'b1; enable_in = 1'b0;
        tick();
        stop_in = 1'b0;
        n_checks++;
        if (busy_out !== 1'b0 || tc_out !== 1'b0 || count_out !== 4'd1) begin
            n_fail++;
            $display("FAIL periodic_stop busy=%b tc=%b count=%0d required 0/0/1", busy_out, tc_out, count_out);
        end
    endtask

    task automatic test_gaps_and_stop();
        logic [3:0] exp_cnt [4] = '{4'd3, 4'd3, 4'd2, 4'd2};
        load_in = 1'b1; load_value_in = 4'd4; start_in = 1'b1; mode_in = 1'b0; enable_in = 1'b0;
        tick();
        load_in = 1'b0; start_in = 1'b0;
        n_checks++;
        if (count_out !== 4'd4) begin
            n_fail++;
            $display("FAIL gaps_start count=%0d required 4", count_out);
        end
        for (int i = 0; i < 4; i++) begin
            enable_in = (i % 2 == 0);
            tick();
            n_checks++;
            if (count_out !== exp_cnt[i] || tc_out !== 1'b0) begin
                n_fail++;
                $display("FAIL gaps_step%0d count=%0d tc=%b required %0d/0", i, count_out, tc_out, exp_cnt[i]);
            end
        end
        stop_in = 1'b1; enable_in = 1'b1;
        tick();
        stop_in = 1'b0;
        tick(); tick();
        n_checks++;
        if (count_out !== 4'd2 || busy_out !== 1'b0 || tc_out !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_hold count=%0d busy=%b tc=%b required 2/0/0", count_out, busy_out, tc_out);
        end
        enable_in = 1'b0;
    endtask

    task automatic test_simultaneous();
        load_in = 1'b1; load_value_in = 4'd7; start_in = 1'b1; mode_in = 1'b0;
        tick();
        load_in = 1'b0; start_in = 1'b0;
        n_checks++;
        if (count_out !== 4'd7 || busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL load_and_start count=%0d busy=%b required 7/1", count_out, busy_out);
        end
        stop_in = 1'b1;
        tick();
        start_in = 1'b1;
        tick();
        start_in = 1'b0; stop_in = 1'b0;
        n_checks++;
        if (busy_out !== 1'b0 || count_out !== 4'd7) begin
            n_fail++;
            $display("FAIL start_stop_ignored busy=%b count=%0d required 0/7", busy_out, count_out);
        end
        load_in = 1'b1; load_value_in = 4'd2; start_in = 1'b1;
        tick();
        load_in = 1'b0; start_in = 1'b0; enable_in = 1'b1;
        tick();
        n_checks++;
        if (count_out !== 4'd1) begin
            n_fail++;
            $display("FAIL restart_setup count=%0d required 1", count_out);
        end
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        n_checks++;
        if (count_out !== 4'd2 || tc_out !== 1'b0 || busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_at_one count=%0d tc=%b busy=%b required 2/0/1", count_out, tc_out, busy_out);
        end
        tick(); tick();
        n_checks++;
        if (count_out !== 4'd0 || tc_out !== 1'b1 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_expiry count=%0d tc=%b busy=%b required 0/1/0", count_out, tc_out, busy_out);
        end
        enable_in = 1'b0;
    endtask

    task automatic test_async_reset();
        bit saw_tc = 1'b0;
        load_in = 1'b1; load_value_in = 4'd3; start_in = 1'b1; mode_in = 1'b1;
        tick();
        load_in = 1'b0; start_in = 1'b0;
        n_checks++;
        if (count_out !== 4'd3 || busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL async_setup count=%0d busy=%b required 3/1", count_out, busy_out);
        end
        #2;
        reset_ah_in = 1'b1;
        #1;
        n_checks++;
        if ({count_out, tc_out, busy_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset count=%0d tc=%b busy=%b required 0/0/0", count_out, tc_out, busy_out);
        end
        #1;
        reset_ah_in = 1'b0;
        enable_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tc_out !== 1'b0) saw_tc = 1'b1;
        end
        n_checks++;
        if (saw_tc || busy_out !== 1'b0 || count_out !== 4'd0) begin
            n_fail++;
            $display("FAIL post_reset_quiet saw_tc=%b busy=%b count=%0d required 0/0/0", saw_tc, busy_out, count_out);
        end
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        n_checks++;
        if (busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_r_cleared busy=%b required 0", busy_out);
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_gaps_and_stop();
        test_simultaneous();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_down_sync_timer.md
# counter_down_sync_timer

Fully synchronous, parameterised down-counting timer: the counting-down counterpart of the team's ripple up-counters. It loads a reload value, counts it down on enabled clock cycles and emits a single-cycle terminal-count pulse, in one-shot or periodic mode. It sits beside the up-counters as the interval and timeout source for controllers in the same design.

## Interface
Parameters:
- WIDTH, 4: counter and reload width in bits; legal range is 2..16.

Ports:
- clk  input  1  sole clock; everything is rising-edge.
- reset_ah_in  input  1  asynchronous, active-high reset.
- load_in  input  1  writes load_value_in into the reload register R.
- load_value_in  input  WIDTH  new reload value.
- start_in  input  1  starts or restarts a count from R.
- stop_in  input  1  aborts a running count; count_out is held.
- enable_in  input  1  count-enable qualifier, sampled every cycle in RUN.
- mode_in  input  1  0 = one-shot, 1 = periodic; latched at start.
- count_out  output  WIDTH  current count, registered.
- tc_out  output  1  terminal-count pulse, registered, one cycle wide.
- busy_out  output  1  high while the state is RUN.

## Operation
- States are IDLE, RUN and EXPIRED. Reset values: state IDLE, R=0, count_out=0, tc_out=0, busy_out=0, latched mode=0.
- load_in is accepted in any state. It updates R only and never changes count_out.
- R_eff is load_value_in if load_in is high in the same cycle, otherwise R.
- Start decision, in priority order:
  - stop_in high: the start is ignored.
  - start_in high with R_eff != 0, in any state: count_out <= R_eff, mode is latched from mode_in, state becomes RUN.
  - start_in high with R_eff == 0: the start is ignored and the state and count are unchanged.
- stop_in in RUN: state becomes IDLE and count_out holds its value. stop_in in IDLE or EXPIRED has no effect.
- RUN with enable_in low: count_out holds.
- RUN with enable_in high and count_out > 1: count_out decrements by 1.
- RUN with enable_in high and count_out == 1:
  - One-shot: count_out <= 0, tc_out <= 1, state becomes EXPIRED.
  - Periodic: count_out <= R (current R, or load_value_in if load_in is high that cycle), tc_out <= 1, state stays RUN.
- In periodic mode count_out never shows 0. The period is exactly R enabled cycles.
- EXPIRED: count_out holds 0 and busy_out is low. The next valid start re-enters RUN.
- A start in RUN restarts the count and suppresses any tc_out for that edge.
- Arithmetic is unsigned, modulo 2^WIDTH. Underflow below 0 cannot occur. R = 2^WIDTH-1 is legal.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- The start edge loads count_out, which is visible in the next cycle. The first decrement happens on the following enabled edge.
- After a start with R=N and enable_in held high, tc_out is high in the cycle N edges after the start edge.
- tc_out is high for exactly one cycle per expiry, including back-to-back periods with R=1.
- Reset asserted mid-count forces all reset values immediately (asynchronously). On deassertion the block is in IDLE; no tc_out is produced.

## Structure
- Package counter_pkg holds the state enum (IDLE, RUN, EXPIRED) and the WIDTH bounds constants.
- One sub-module, counter_down_core: a WIDTH-bit register with load, decrement-enable, an is_one flag and async reset.
- The top level holds the reload register, the FSM and the tc/busy registers.

## Test plan
- Reset then idle: count_out=0, tc_out=0, busy_out=0 with no activity. start_in with R=0 stays IDLE.
- One-shot, R=5, enable_in high: count_out reads 5,4,3,2,1,0. tc_out pulses once, together with 0. busy_out falls and the state is EXPIRED.
- Periodic, R=3, enable_in high for 10 cycles: count_out reads 3,2,1,3,2,1,… and tc_out pulses every 3rd cycle. With R=1, tc_out pulses every cycle.
- Gaps and stop: one-shot, R=4, enable_in toggling 1,0,1,0 → count advances only on enabled cycles. stop_in at count 2 → IDLE, count_out holds 2, no tc_out.
- Simultaneous events:
  - load_in=1 with load_value_in=7 and start_in=1 → count_out=7.
  - start_in and stop_in together → ignored.
  - Restart in RUN at count 1 → count_out reloads and tc_out stays low.
- Async reset mid-count (count_out=3, periodic) asserted between edges → outputs go to reset values without waiting for clk. No tc_out after release.
